// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution operand streamer.
// No logic; compile-time only.
package conv_pkg;
    localparam int FP_W = 32;
    localparam logic SEL_IMG = 1'b0;
    localparam logic SEL_KER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int conv_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/conv_win_addr_gen.sv
// Window walker: r/c/i/j counters mapped to image and kernel word addresses.
// Latency: addresses are combinational from the counters; counters step on i_advance.
// Backpressure: counters hold whenever i_advance is low.
module conv_win_addr_gen
    import conv_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 2,
    localparam int M   = N - K + 1,
    localparam int AW  = conv_clog2(N * N),
    localparam int KAW = conv_clog2(K * K),
    localparam int CW  = conv_clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_advance,
    output logic [AW-1:0]  o_img_addr,
    output logic [KAW-1:0] o_ker_addr,
    output logic           o_last_in_win,
    output logic           o_last_in_frame
);
    logic [CW-1:0] r_r, r_c, r_i, r_j;
    logic [AW-1:0] w_row, w_col;

    assign w_row = AW'(r_r) + AW'(r_i);
    assign w_col = AW'(r_c) + AW'(r_j);
    assign o_img_addr = w_row * AW'(N) + w_col;
    assign o_ker_addr = KAW'(r_i) * KAW'(K) + KAW'(r_j);

    assign o_last_in_win   = (r_i == CW'(K - 1)) && (r_j == CW'(K - 1));
    assign o_last_in_frame = o_last_in_win && (r_r == CW'(M - 1)) && (r_c == CW'(M - 1));

    // Ripple-carry style nesting: j is innermost, r outermost; all wrap to 0 after the last beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_r <= '0;
            r_c <= '0;
            r_i <= '0;
            r_j <= '0;
        end else if (i_advance) begin
            if (r_j != CW'(K - 1)) begin
                r_j <= r_j + 1'b1;
            end else begin
                r_j <= '0;
                if (r_i != CW'(K - 1)) begin
                    r_i <= r_i + 1'b1;
                end else begin
                    r_i <= '0;
                    if (r_c != CW'(M - 1)) begin
                        r_c <= r_c + 1'b1;
                    end else begin
                        r_c <= '0;
                        r_r <= (r_r != CW'(M - 1)) ? r_r + 1'b1 : '0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/conv_operand_streamer.sv
// Streams (image, kernel) operand pairs window by window into the convolution core.
// Latency: first pair valid the cycle after start; then one pair per accepted beat.
// Backpressure: op_valid/op_ready; outputs hold while op_ready is low.
module conv_operand_streamer
    import conv_pkg::*;
#(
    parameter int N  = 3,
    parameter int K  = 2,
    parameter int DW = FP_W,
    localparam int AW  = conv_clog2(N * N),
    localparam int KAW = conv_clog2(K * K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          op_valid,
    input  logic          op_ready,
    output logic          op_last,
    output logic          frame_done
);
    state_t r_state;
    logic   r_frame_last;

    logic [DW-1:0] r_img_mem [N*N];
    logic [DW-1:0] r_ker_mem [K*K];

    logic [AW-1:0]  w_img_addr;
    logic [KAW-1:0] w_ker_addr;
    logic           w_last_in_win, w_last_in_frame;
    logic           w_load, w_wr_ok, w_img_in, w_ker_in;
    logic [DW-1:0]  w_a_rd, w_b_rd;

    assign w_load = ((r_state == ST_IDLE) && start) ||
                    ((r_state == ST_STREAM) && op_ready && !r_frame_last);

    conv_win_addr_gen #(.N(N), .K(K)) u_addr (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_advance      (w_load),
        .o_img_addr     (w_img_addr),
        .o_ker_addr     (w_ker_addr),
        .o_last_in_win  (w_last_in_win),
        .o_last_in_frame(w_last_in_frame)
    );

    assign w_wr_ok  = wr_en && (r_state == ST_IDLE);
    assign w_img_in = ({1'b0, wr_addr} < (AW + 1)'(N * N));
    assign w_ker_in = ({1'b0, wr_addr} < (AW + 1)'(K * K));

    // Forward a same-cycle write so start+write in IDLE sees the new word on the first beat.
    assign w_a_rd = (w_wr_ok && wr_sel == SEL_IMG && wr_addr == w_img_addr)
                    ? wr_data : r_img_mem[w_img_addr];
    assign w_b_rd = (w_wr_ok && wr_sel == SEL_KER && wr_addr == AW'(w_ker_addr))
                    ? wr_data : r_ker_mem[w_ker_addr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            if (wr_sel == SEL_IMG) begin
                if (w_img_in) r_img_mem[wr_addr] <= wr_data;
            end else if (w_ker_in) begin
                r_ker_mem[wr_addr[KAW-1:0]] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_last <= 1'b0;
            busy         <= 1'b0;
            op_valid     <= 1'b0;
            op_last      <= 1'b0;
            frame_done   <= 1'b0;
            a_out        <= '0;
            b_out        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        r_state      <= ST_STREAM;
                        busy         <= 1'b1;
                        op_valid     <= 1'b1;
                        a_out        <= w_a_rd;
                        b_out        <= w_b_rd;
                        op_last      <= w_last_in_win;
                        r_frame_last <= w_last_in_frame;
                    end
                end
                ST_STREAM: begin
                    if (op_ready) begin
                        if (r_frame_last) begin
                            r_state      <= ST_DONE;
                            op_valid     <= 1'b0;
                            op_last      <= 1'b0;
                            r_frame_last <= 1'b0;
                            frame_done   <= 1'b1;
                        end else begin
                            a_out        <= w_a_rd;
                            b_out        <= w_b_rd;
                            op_last      <= w_last_in_win;
                            r_frame_last <= w_last_in_frame;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_operand_streamer.sv
// Directed bench for conv_operand_streamer: N=3/K=2 main instance plus N=3/K=3 and N=4/K=1 sweeps.
module tb_conv_operand_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, wr_sel, start, start33, start41, op_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    logic        busy, op_valid, op_last, frame_done;
    logic [31:0] a_out, b_out;
    logic        busy33, v33, l33, fd33;
    logic [31:0] a33, b33;
    logic        busy41, v41, l41, fd41;
    logic [31:0] a41, b41;

    conv_operand_streamer #(.N(3), .K(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .a_out(a_out), .b_out(b_out),
        .op_valid(op_valid), .op_ready(op_ready), .op_last(op_last), .frame_done(frame_done));

    conv_operand_streamer #(.N(3), .K(3)) dut33 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start33), .busy(busy33), .a_out(a33), .b_out(b33),
        .op_valid(v33), .op_ready(op_ready), .op_last(l33), .frame_done(fd33));

    conv_operand_streamer #(.N(4), .K(1)) dut41 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start41), .busy(busy41), .a_out(a41), .b_out(b41),
        .op_valid(v41), .op_ready(op_ready), .op_last(l41), .frame_done(fd41));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] img_w [9]  = '{32'h3F99999A, 32'hC0200000, 32'h4059999A, 32'hBF4CCCCD,
                                32'h40066666, 32'hC0733333, 32'h3F19999A, 32'hBFA66666,
                                32'h40366666};
    logic [31:0] ker_w [4]  = '{32'h3F000000, 32'hBFF19999, 32'hBF666666, 32'h40133333};
    logic [31:0] exp_a [16] = '{32'h3F99999A, 32'hC0200000, 32'hBF4CCCCD, 32'h40066666,
                                32'hC0200000, 32'h4059999A, 32'h40066666, 32'hC0733333,
                                32'hBF4CCCCD, 32'h40066666, 32'h3F19999A, 32'hBFA66666,
                                32'h40066666, 32'hC0733333, 32'hBFA66666, 32'h40366666};

    logic [64:0] q0[$], q33[$], q41[$];
    int          c0[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Beats seen valid&ready at the falling edge are the ones accepted at the next rising edge.
    always @(negedge clk) begin
        if (op_valid && op_ready) begin
            q0.push_back({op_last, a_out, b_out});
            c0.push_back(cyc);
        end
        if (v33 && op_ready) q33.push_back({l33, a33, b33});
        if (v41 && op_ready) q41.push_back({l41, a41, b41});
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic sel, input int addr, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] k0);
        chk({tag, "_count"}, 72'(q0.size()), 72'd16);
        for (int n = 0; n < 16 && n < q0.size(); n++) begin
            logic [31:0] eb;
            eb = (n % 4 == 0) ? k0 : ker_w[n % 4];
            chk($sformatf("%s_beat%0d", tag, n + 1), 72'(q0[n]), 72'({(n % 4 == 3), exp_a[n], eb}));
        end
    endtask

    task automatic run_frame(input string tag, input bit stall, input bit inject, input int rst_at);
        int nacc, stall_left, start_cyc;
        bit hs, done;
        logic [64:0] snap;
        nacc = 0; stall_left = 3; done = 0;
        q0.delete(); c0.delete();
        op_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        start_cyc = cyc;
        chk({tag, "_first_vld"}, 72'(op_valid), 72'd1);
        chk({tag, "_first_busy"}, 72'(busy), 72'd1);
        for (int n = 0; n < 200 && !done; n++) begin
            op_ready = !(stall && nacc == 5 && stall_left > 0);
            if (!op_ready) stall_left--;
            if (inject && nacc == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 32'h3F800000;
            end
            if (rst_at != 0 && nacc == rst_at - 1) rst = 1'b1;
            hs = op_valid && op_ready;
            snap = {op_last, a_out, b_out};
            tick();
            start = 1'b0; wr_en = 1'b0;
            if (rst) begin
                rst = 1'b0;
                done = 1;
                chk({tag, "_rst_vld"}, 72'(op_valid), 72'd0);
                chk({tag, "_rst_busy"}, 72'(busy), 72'd0);
                chk({tag, "_rst_done"}, 72'(frame_done), 72'd0);
                tick();
                chk({tag, "_rst_nodone"}, 72'({frame_done, busy, op_valid}), 72'd0);
                chk({tag, "_rst_beats"}, 72'(q0.size()), 72'(rst_at));
            end else begin
                if (hs) nacc++;
                else if (op_valid) chk({tag, "_hold"}, 72'({op_last, a_out, b_out}), 72'(snap));
                if (frame_done) begin
                    done = 1;
                    chk({tag, "_done_busy"}, 72'(busy), 72'd1);
                    chk({tag, "_done_vld"}, 72'(op_valid), 72'd0);
                    if (c0.size() > 0) begin
                        chk({tag, "_done_cyc"}, 72'(cyc), 72'(c0[c0.size() - 1] + 1));
                        chk({tag, "_first_cyc"}, 72'(c0[0]), 72'(start_cyc));
                        chk({tag, "_span"}, 72'(c0[c0.size() - 1] - c0[0]), 72'(stall ? 18 : 15));
                    end
                    tick();
                    chk({tag, "_idle_busy"}, 72'(busy), 72'd0);
                    chk({tag, "_idle_done"}, 72'(frame_done), 72'd0);
                end
            end
        end
        if (!done) chk({tag, "_timeout"}, 72'd0, 72'd1);
        op_ready = 1'b1;
    endtask

    initial begin
        bit d33, d41;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start33 = 1'b0; start41 = 1'b0; op_ready = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_vld", 72'(op_valid), 72'd0);
        chk("rst_last", 72'(op_last), 72'd0);
        chk("rst_done", 72'(frame_done), 72'd0);
        chk("rst_a", 72'(a_out), 72'd0);
        chk("rst_b", 72'(b_out), 72'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 9; k++) write(1'b0, k, img_w[k]);
        for (int k = 0; k < 4; k++) write(1'b1, k, ker_w[k]);
        write(1'b1, 4, 32'hDEADBEEF);

        run_frame("s1", 0, 0, 0);
        check_frame("s1", 32'h3F000000);

        run_frame("s3", 1, 0, 0);
        check_frame("s3", 32'h3F000000);

        run_frame("s4a", 0, 1, 0);
        check_frame("s4a", 32'h3F000000);
        run_frame("s4b", 0, 0, 0);
        check_frame("s4b", 32'h3F000000);

        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 32'h3F800000;
        run_frame("s4c", 0, 0, 0);
        check_frame("s4c", 32'h3F800000);
        write(1'b1, 0, 32'h3F000000);

        run_frame("s5", 0, 0, 7);
        run_frame("s5r", 0, 0, 0);
        check_frame("s5r", 32'h3F000000);

        for (int k = 0; k < 16; k++) write(1'b0, k, 32'h100 + 32'(k));
        for (int k = 0; k < 9; k++) write(1'b1, k, 32'h200 + 32'(k));
        q33.delete(); q41.delete();
        op_ready = 1'b1;
        start33 = 1'b1; start41 = 1'b1;
        tick();
        start33 = 1'b0; start41 = 1'b0;
        d33 = 0; d41 = 0;
        for (int n = 0; n < 100 && !(d33 && d41); n++) begin
            tick();
            if (fd33) d33 = 1;
            if (fd41) d41 = 1;
        end
        chk("k3_done", 72'(d33), 72'd1);
        chk("k1_done", 72'(d41), 72'd1);
        chk("k3_count", 72'(q33.size()), 72'd9);
        for (int n = 0; n < 9 && n < q33.size(); n++)
            chk($sformatf("k3_beat%0d", n + 1), 72'(q33[n]),
                72'({(n == 8), 32'h100 + 32'(n), 32'h200 + 32'(n)}));
        chk("k1_count", 72'(q41.size()), 72'd16);
        for (int n = 0; n < 16 && n < q41.size(); n++)
            chk($sformatf("k1_beat%0d", n + 1), 72'(q41[n]),
                72'({1'b1, 32'h100 + 32'(n), 32'h200}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
